seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles per digit slot (minimum 4).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, giving the anode-off cycles at the start of each digit slot (less than REFRESH_DIV).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port value_in, input, 16 bits: the processor test_value to display as 4 hex digits.
REQ-006 SHALL have port freeze, input, 1 bit: when high, holds the displayed snapshot.
REQ-007 SHALL have port seg_n, output, 7 bits: active-low segments, with bit0 = a through bit6 = g.
REQ-008 SHALL have port an_n, output, 4 bits: active-low digit enables, with an_n[0] the rightmost digit (value_in[3:0]).
REQ-009 SHALL have port dp_n, output, 1 bit: active-low decimal point.

Function
REQ-010 SHALL contain a prescaler counting 0 to REFRESH_DIV-1 and wrapping to 0; tick = (prescaler == REFRESH_DIV-1).
REQ-011 SHALL advance the 2-bit digit index on each tick: 0→1→2→3→0.
REQ-012 SHALL load the 16-bit snapshot from value_in on a tick while index==3 (frame boundary) and freeze==0; otherwise the snapshot SHALL hold, so no frame tears.
REQ-013 SHALL register all outputs, so pins reflect prescaler, index and snapshot state with exactly 1 cycle latency.
REQ-014 SHALL drive an_n as one-hot low at the index position, except that an_n = 4'b1111 while prescaler < BLANK_CYCLES (ghost suppression).
REQ-015 SHALL drive seg_n as the hex decode of snapshot nibble[index]: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-016 SHALL drive seg_n = 7'h7F whenever an_n is all ones.
REQ-017 SHALL drive dp_n = 0 only when index==0, freeze==1 and the digit is not blanked, as a freeze indicator; otherwise dp_n = 1.
REQ-018 SHALL give precedence to the frame-boundary load when freeze deasserts and the boundary tick occur in the same cycle (freeze sampled that cycle, value 0 → load).
REQ-019 SHALL apply a value_in change to the snapshot only at the next frame boundary; intermediate changes SHALL be ignored.

Reset
REQ-020 SHALL, while RST is low and asynchronously, force prescaler=0, index=0, snapshot=16'h0000, an_n=4'b1111, seg_n=7'h7F, dp_n=1.
REQ-021 SHALL, after RST rises mid-scan, restart the scan at index 0 with prescaler 0 and with no partial-slot carry-over.

Configuration
REQ-022 SHALL compile leading-zero blanking in with macro SEG7_LEADING_ZERO_BLANK_EN.
REQ-023 SHALL, with SEG7_LEADING_ZERO_BLANK_EN defined, force an_n fully high for digit k (k=3..1) when snapshot nibbles k..3 are all zero; digit 0 SHALL always display.
REQ-024 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, display all four digits, including leading zeros, and use no blanking logic.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-025 SHALL cover reset: RST low mid-operation → an_n=4'hF, seg_n=7'h7F, dp_n=1 in the same cycle, with no clock edge needed.
REQ-026 SHALL cover scan/decode: value_in=16'h1234 after reset → first frame (32 cycles) shows 7'h40 on all digits; second frame shows digit0=7'h19, digit1=7'h30, digit2=7'h24, digit3=7'h79, each with an_n low for 6 of 8 cycles.
REQ-027 SHALL cover blanking: every slot's first 2 cycles (+1 latency) → an_n=4'hF and seg_n=7'h7F.
REQ-028 SHALL cover freeze: snapshot 16'h1234, freeze=1, value_in→16'hABCD for 3 frames → display stays 1234 and digit0 dp_n=0; freeze=0 → ABCD appears at the next frame boundary.
REQ-029 SHALL cover leading-zero blanking: value_in=16'h0005 with the macro → only an_n[0] ever low, seg_n=7'h12; without the macro → digits 3..1 show 7'h40.
REQ-030 SHALL cover reset mid-scan: RST pulsed low during index 2 → after release, the first enabled anode is an_n=4'b1110 at cycle BLANK_CYCLES+1.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit hex display driver for a common-anode 7-segment module.
// Optional leading-zero blanking is compiled in with SEG7_LEADING_ZERO_BLANK_EN.

module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] segN
);
  always_comb begin
    segN = 7'h7F;
    unique case (nibble)
      4'h0: segN = 7'h40;
      4'h1: segN = 7'h79;
      4'h2: segN = 7'h24;
      4'h3: segN = 7'h30;
      4'h4: segN = 7'h19;
      4'h5: segN = 7'h12;
      4'h6: segN = 7'h02;
      4'h7: segN = 7'h78;
      4'h8: segN = 7'h00;
      4'h9: segN = 7'h10;
      4'hA: segN = 7'h08;
      4'hB: segN = 7'h03;
      4'hC: segN = 7'h46;
      4'hD: segN = 7'h21;
      4'hE: segN = 7'h06;
      4'hF: segN = 7'h0E;
      default: segN = 7'h7F;
    endcase
  end
endmodule

module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] value_in,
  input  logic        freeze,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        dp_n
);
  localparam int NUM_DIGITS = 4;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PMAX  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);

  logic [PW-1:0] prescaler;
  logic [1:0]    digitIdx;
  logic [NUM_DIGITS-1:0][3:0] snapshot;
  logic          tick;

  assign tick = (prescaler == PMAX);

  // Snapshot only reloads at the frame boundary so a frame never mixes two values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescaler <= '0;
      digitIdx  <= '0;
      snapshot  <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) digitIdx <= digitIdx + 2'd1;
      if (tick && digitIdx == 2'd3 && !freeze) snapshot <= value_in;
    end
  end

  logic [NUM_DIGITS-1:0][6:0] digitSeg;
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
    seg7_hex_decode uDec (.nibble(snapshot[d]), .segN(digitSeg[d]));
  end

  logic [NUM_DIGITS-1:0] lzBlank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Digit k is dark when it and every more-significant nibble are zero.
  assign lzBlank[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
    assign lzBlank[k] = ~|snapshot[NUM_DIGITS-1:k];
  end
`else
  assign lzBlank = '0;
`endif

  logic       digitBlank;
  logic [3:0] anNext;
  logic [6:0] segNext;
  logic       dpNext;

  always_comb begin
    digitBlank = (prescaler < BLANK) || lzBlank[digitIdx];
    anNext     = 4'hF;
    segNext    = 7'h7F;
    dpNext     = 1'b1;
    if (!digitBlank) begin
      anNext  = ~(4'b0001 << digitIdx);
      segNext = digitSeg[digitIdx];
      dpNext  = !(digitIdx == 2'd0 && freeze);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      an_n  <= 4'hF;
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= anNext;
      seg_n <= segNext;
      dp_n  <= dpNext;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: driver pushes model expectations, monitor pops and compares.
module tb_seg7_scan_driver;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] value_in = '0;
  logic        freeze = 1'b0;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        dp_n;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .CLK(CLK), .RST(RST), .value_in(value_in), .freeze(freeze),
    .seg_n(seg_n), .an_n(an_n), .dp_n(dp_n)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;
  bit   started = 0;
  bit   done = 0;
  int   cyc = 0;

  // Reference model: time since reset release and the latched display value.
  int          n = 0;
  logic [15:0] snap = '0;

  function automatic logic [6:0] hexSeg(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[d];
  endfunction

  function automatic int modelIdx();
    return (n / RD) % 4;
  endfunction

  task automatic step(input logic rstv, input logic [15:0] v, input logic frz);
    exp_t e;
    int phase, idx;
    bit blank;
    @(negedge CLK);
    RST = rstv; value_in = v; freeze = frz;
    e = '{seg: 7'h7F, an: 4'hF, dp: 1'b1};
    if (!rstv) begin
      n = 0;
      snap = '0;
      #1;
      tests++;
      if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
        fails++;
        $display("FAIL async_reset t=%0t got an=%h seg=%h dp=%b want an=f seg=7f dp=1",
                 $time, an_n, seg_n, dp_n);
      end
    end else begin
      phase = n % RD;
      idx   = (n / RD) % 4;
      blank = (phase < BC);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx > 0 && (snap >> (4 * idx)) == 16'h0) blank = 1'b1;
`endif
      if (!blank) begin
        e.an  = ~(4'b0001 << idx);
        e.seg = hexSeg(4'((snap >> (4 * idx)) & 16'hF));
        e.dp  = !(idx == 0 && frz);
      end
      if (phase == RD - 1 && idx == 3 && !frz) snap = v;
      n++;
    end
    expQ.push_back(e);
    started = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (done) break;
      if (started) begin
        cyc++;
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_underflow cyc=%0d got no expectation", cyc);
        end else begin
          e = expQ.pop_front();
          if (seg_n !== e.seg || an_n !== e.an || dp_n !== e.dp) begin
            fails++;
            $display("FAIL scan cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                     cyc, an_n, seg_n, dp_n, e.an, e.seg, e.dp);
          end
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] v;
    logic        f;
    int          guard;
    // Reset held, then the 1234 scan: one frame of zeros, then 1234.
    repeat (3) step(1'b0, 16'h1234, 1'b0);
    repeat (64) step(1'b1, 16'h1234, 1'b0);
    // Freeze with a new value presented for three frames.
    repeat (96) step(1'b1, 16'hABCD, 1'b1);
    // Release freeze exactly on the boundary tick; the load must win.
    guard = 0;
    while (n % (4 * RD) != 4 * RD - 1 && guard < 64) begin
      step(1'b1, 16'hABCD, 1'b1);
      guard++;
    end
    repeat (40) step(1'b1, 16'hABCD, 1'b0);
    // Leading-zero case.
    repeat (72) step(1'b1, 16'h0005, 1'b0);
    // Randomized value churn and freeze toggling.
    v = 16'($urandom);
    f = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) v = 16'($urandom);
      if ($urandom_range(4) == 0) v = v & 16'h00FF;
      if ($urandom_range(19) == 0) f = ~f;
      step(1'b1, v, f);
    end
    // Reset pulse while the scan is on digit 2.
    guard = 0;
    while (!(modelIdx() == 2 && n % RD == 3) && guard < 64) begin
      step(1'b1, 16'h5A3C, 1'b0);
      guard++;
    end
    repeat (2) step(1'b0, 16'h5A3C, 1'b0);
    repeat (80) step(1'b1, 16'h5A3C, 1'b0);
    // A few random mid-scan resets.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(5, 40)) step(1'b1, 16'($urandom), 1'b0);
      step(1'b0, 16'h0, 1'b0);
      repeat (40) step(1'b1, 16'($urandom), $urandom_range(1) == 1);
    end
    @(posedge CLK);
    #3;
    done = 1;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d left want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
